// File: rtl/id_pkg.sv
// Shared ID-stage definitions: clear FSM encoding and the hardwired-zero index.
// Also imported by hazard/forwarding logic.
package id_pkg;

    localparam logic [0:0] S_CLEAR  = 1'b0;
    localparam logic [0:0] S_RUN    = 1'b1;

    localparam int         REG_ZERO = 0;

endpackage

// File: rtl/id_regfile_read_port.sv
// One combinational register-file read port.
// Applies the range, hardwired-zero and write-first bypass rules.
module id_regfile_read_port
    import id_pkg::*;
#(
    parameter int NB_DATA   = 32,
    parameter int SIZE_REG  = 32,
    parameter int NB_REG    = 5,
    parameter int ZERO_REG0 = 1,
    parameter int BYPASS    = 1
) (
    input  logic [NB_REG-1:0]  address,
    input  logic [NB_DATA-1:0] regs [SIZE_REG],
    input  logic               pipe_commit,
    input  logic [NB_REG-1:0]  pipe_address,
    input  logic [NB_DATA-1:0] pipe_data,
    input  logic               dbg_commit,
    input  logic [NB_REG-1:0]  dbg_address,
    input  logic [NB_DATA-1:0] dbg_data,
    input  logic [0:0]         state,
    output logic [NB_DATA-1:0] data
);

    localparam logic [NB_REG:0] LIMIT = (NB_REG+1)'(SIZE_REG);

    logic in_range;
    logic is_zero;

    assign in_range = {1'b0, address} < LIMIT;
    assign is_zero  = (ZERO_REG0 != 0) && (address == NB_REG'(REG_ZERO));

    // Commits are pre-qualified, so a discarded write can never bypass.
    always_comb begin
        data = '0;
        if (state == S_RUN && in_range && !is_zero) begin
            data = regs[address];
            if (BYPASS != 0) begin
                if (dbg_commit && dbg_address == address)
                    data = dbg_data;
                if (pipe_commit && pipe_address == address)
                    data = pipe_data;
            end
        end
    end

endmodule

// File: rtl/id_register_file_mp.sv
// ID-stage multi-port register file with post-reset clear engine,
// pipeline/debug write arbitration and optional write-first bypass.
module id_register_file_mp
    import id_pkg::*;
#(
    parameter int NB_DATA   = 32,
    parameter int SIZE_REG  = 32,
    parameter int NB_REG    = 5,
    parameter int N_RD      = 2,
    parameter int ZERO_REG0 = 1,
    parameter int BYPASS    = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [N_RD*NB_REG-1:0]  i_address_rd,
    output logic [N_RD*NB_DATA-1:0] o_data_rd,
    input  logic                    i_write_data,
    input  logic [NB_REG-1:0]       i_address_data,
    input  logic [NB_DATA-1:0]      i_data_input,
    input  logic                    i_write_debug_reg_file,
    input  logic [NB_REG-1:0]       i_address_write_debug,
    input  logic [NB_DATA-1:0]      i_write_data_debug,
    input  logic [NB_REG-1:0]       i_address_read_debug,
    output logic [NB_DATA-1:0]      o_data_read_debug,
    output logic                    o_ready,
    output logic                    o_wr_conflict
);

    localparam logic [NB_REG:0]   LIMIT = (NB_REG+1)'(SIZE_REG);
    localparam logic [NB_REG-1:0] LAST  = NB_REG'(SIZE_REG-1);

    logic [0:0]         state;
    logic [NB_REG-1:0]  cnt;
    logic [NB_DATA-1:0] regs [SIZE_REG];

    logic run;
    logic collision;
    logic pipe_commit;
    logic dbg_commit;

    function automatic logic writable(input logic [NB_REG-1:0] a);
        return ({1'b0, a} < LIMIT) &&
               !((ZERO_REG0 != 0) && (a == NB_REG'(REG_ZERO)));
    endfunction

    assign run       = (state == S_RUN) && !i_reset;
    assign collision = i_write_data && i_write_debug_reg_file &&
                       (i_address_data == i_address_write_debug);

    // Pipeline wins a same-address collision; the debug write is dropped.
    assign pipe_commit = run && i_write_data &&
                         writable(i_address_data);
    assign dbg_commit  = run && i_write_debug_reg_file && !collision &&
                         writable(i_address_write_debug);

    assign o_ready = (state == S_RUN);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_CLEAR;
            cnt           <= '0;
            o_wr_conflict <= 1'b0;
        end else begin
            o_wr_conflict <= (state == S_RUN) && collision;
            if (state == S_CLEAR) begin
                cnt <= cnt + 1'b1;
                if (cnt == LAST)
                    state <= S_RUN;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (state == S_CLEAR) begin
                regs[cnt] <= '0;
            end else begin
                if (dbg_commit)
                    regs[i_address_write_debug] <= i_write_data_debug;
                if (pipe_commit)
                    regs[i_address_data] <= i_data_input;
            end
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        id_regfile_read_port #(
            .NB_DATA  (NB_DATA),
            .SIZE_REG (SIZE_REG),
            .NB_REG   (NB_REG),
            .ZERO_REG0(ZERO_REG0),
            .BYPASS   (BYPASS)
        ) u_rd (
            .address     (i_address_rd[k*NB_REG +: NB_REG]),
            .regs        (regs),
            .pipe_commit (pipe_commit),
            .pipe_address(i_address_data),
            .pipe_data   (i_data_input),
            .dbg_commit  (dbg_commit),
            .dbg_address (i_address_write_debug),
            .dbg_data    (i_write_data_debug),
            .state       (state),
            .data        (o_data_rd[k*NB_DATA +: NB_DATA])
        );
    end

    id_regfile_read_port #(
        .NB_DATA  (NB_DATA),
        .SIZE_REG (SIZE_REG),
        .NB_REG   (NB_REG),
        .ZERO_REG0(ZERO_REG0),
        .BYPASS   (BYPASS)
    ) u_rd_dbg (
        .address     (i_address_read_debug),
        .regs        (regs),
        .pipe_commit (pipe_commit),
        .pipe_address(i_address_data),
        .pipe_data   (i_data_input),
        .dbg_commit  (dbg_commit),
        .dbg_address (i_address_write_debug),
        .dbg_data    (i_write_data_debug),
        .state       (state),
        .data        (o_data_read_debug)
    );

endmodule

// File: tb/tb_id_register_file_mp.sv
// Scoreboard bench: two configurations of id_register_file_mp driven
// with the same write traffic and checked against a behavioural model.
module tb_id_register_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [9:0]  ra_a;
    logic [14:0] ra_b;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        dwe;
    logic [4:0]  dwa;
    logic [31:0] dwd;
    logic [4:0]  dra;

    logic [63:0] rd_a;
    logic [95:0] rd_b;
    logic [31:0] dbg_a, dbg_b;
    logic        rdy_a, rdy_b, cf_a, cf_b;

    // A: defaults (32 regs, zero reg, bypass). B: 24 regs, no zero reg, no bypass.
    id_register_file_mp #(
        .NB_DATA(32), .SIZE_REG(32), .NB_REG(5),
        .N_RD(2), .ZERO_REG0(1), .BYPASS(1)
    ) u_a (
        .i_clk(clk), .i_reset(rst),
        .i_address_rd(ra_a), .o_data_rd(rd_a),
        .i_write_data(we), .i_address_data(wa), .i_data_input(wd),
        .i_write_debug_reg_file(dwe), .i_address_write_debug(dwa),
        .i_write_data_debug(dwd), .i_address_read_debug(dra),
        .o_data_read_debug(dbg_a), .o_ready(rdy_a), .o_wr_conflict(cf_a)
    );

    id_register_file_mp #(
        .NB_DATA(32), .SIZE_REG(24), .NB_REG(5),
        .N_RD(3), .ZERO_REG0(0), .BYPASS(0)
    ) u_b (
        .i_clk(clk), .i_reset(rst),
        .i_address_rd(ra_b), .o_data_rd(rd_b),
        .i_write_data(we), .i_address_data(wa), .i_data_input(wd),
        .i_write_debug_reg_file(dwe), .i_address_write_debug(dwa),
        .i_write_data_debug(dwd), .i_address_read_debug(dra),
        .o_data_read_debug(dbg_b), .o_ready(rdy_b), .o_wr_conflict(cf_b)
    );

    typedef struct packed {
        logic [95:0] rd;
        logic [31:0] dbg;
        logic        rdy;
        logic        cf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [2][32];
    int  size [2] = '{32, 24};
    bit  zero [2] = '{1'b1, 1'b0};
    bit  byp  [2] = '{1'b1, 1'b0};
    bit  ready[2];
    int  left [2];
    bit  conf [2];
    bit  known = 1'b0;

    function automatic bit wr_ok(int i, logic [4:0] a);
        return (int'(a) < size[i]) && !(zero[i] && a == 5'd0);
    endfunction

    function automatic bit pok(int i);
        return !rst && ready[i] && we && wr_ok(i, wa);
    endfunction

    function automatic bit dok(int i);
        return !rst && ready[i] && dwe && wr_ok(i, dwa) &&
               !(we && wa == dwa);
    endfunction

    function automatic logic [31:0] mread(int i, logic [4:0] a);
        logic [31:0] v;
        if (!ready[i]) return 32'd0;
        if (int'(a) >= size[i] || (zero[i] && a == 5'd0)) return 32'd0;
        v = mem[i][a];
        if (byp[i]) begin
            if (dok(i) && dwa == a) v = dwd;
            if (pok(i) && wa == a) v = wd;
        end
        return v;
    endfunction

    function automatic exp_t expect_of(int i);
        exp_t e;
        e = '0;
        if (i == 0) begin
            for (int k = 0; k < 2; k++)
                e.rd[k*32 +: 32] = mread(0, ra_a[k*5 +: 5]);
        end else begin
            for (int k = 0; k < 3; k++)
                e.rd[k*32 +: 32] = mread(1, ra_b[k*5 +: 5]);
        end
        e.dbg = mread(i, dra);
        e.rdy = ready[i];
        e.cf  = conf[i];
        return e;
    endfunction

    task automatic model_edge(int i);
        bit p, d;
        p = pok(i);
        d = dok(i);
        if (rst) begin
            ready[i] = 1'b0;
            left[i]  = size[i];
            conf[i]  = 1'b0;
            known    = 1'b1;
        end else begin
            conf[i] = ready[i] && we && dwe && wa == dwa;
            if (!ready[i]) begin
                left[i]--;
                if (left[i] == 0) begin
                    ready[i] = 1'b1;
                    for (int r = 0; r < 32; r++) mem[i][r] = 32'd0;
                end
            end else begin
                if (d) mem[i][dwa] = dwd;
                if (p) mem[i][wa] = wd;
            end
        end
    endtask

    task automatic step();
        #1;
        if (known) begin
            qa.push_back(expect_of(0));
            qb.push_back(expect_of(1));
        end
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t ea, eb;
        #3;
        if (qa.size() > 0 && qb.size() > 0) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            for (int k = 0; k < 2; k++)
                chk($sformatf("A.rd%0d", k), rd_a[k*32 +: 32], ea.rd[k*32 +: 32]);
            for (int k = 0; k < 3; k++)
                chk($sformatf("B.rd%0d", k), rd_b[k*32 +: 32], eb.rd[k*32 +: 32]);
            chk("A.dbg", dbg_a, ea.dbg);
            chk("B.dbg", dbg_b, eb.dbg);
            chk("A.ready", {31'd0, rdy_a}, {31'd0, ea.rdy});
            chk("B.ready", {31'd0, rdy_b}, {31'd0, eb.rdy});
            chk("A.conflict", {31'd0, cf_a}, {31'd0, ea.cf});
            chk("B.conflict", {31'd0, cf_b}, {31'd0, eb.cf});
        end
    end

    task automatic idle();
        we  = 1'b0;
        dwe = 1'b0;
    endtask

    task automatic set_rd(logic [4:0] a);
        ra_a = {2{a}};
        ra_b = {3{a}};
        dra  = a;
    endtask

    task automatic wr_pipe(logic [4:0] a, logic [31:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
    endtask

    task automatic wr_dbg(logic [4:0] a, logic [31:0] d);
        dwe = 1'b1;
        dwa = a;
        dwd = d;
    endtask

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 3))
            0: return wa;
            1: return dwa;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        ra_a = '0; ra_b = '0; dra = '0;
        we = 1'b0; wa = '0; wd = '0;
        dwe = 1'b0; dwa = '0; dwd = '0;
        @(negedge clk);
        step();
        rst = 1'b0;

        for (int c = 0; c < 36; c++) begin
            set_rd(5'(c));
            idle();
            if (c == 5) begin
                wr_pipe(5'd5, 32'hDEAD);
                wr_dbg(5'd6, 32'hBEEF);
            end
            step();
        end
        idle();
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a));
            step();
        end

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 40; c++) step();

        set_rd(5'd7);
        wr_pipe(5'd7, 32'h12345678);
        step();
        idle();
        step();

        set_rd(5'd0);
        wr_pipe(5'd0, 32'hFFFFFFFF);
        step();
        idle();
        step();

        set_rd(5'd3);
        wr_pipe(5'd3, 32'hAAAA);
        wr_dbg(5'd3, 32'h5555);
        step();
        idle();
        step();
        step();

        set_rd(5'd30);
        wr_pipe(5'd30, 32'hCAFE0030);
        step();
        idle();
        step();
        set_rd(5'd23);
        wr_dbg(5'd23, 32'h1);
        step();
        idle();
        step();

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            we  = 1'($urandom_range(0, 1));
            dwe = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 31));
            dwa = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            wd  = $urandom;
            dwd = $urandom;
            for (int k = 0; k < 2; k++) ra_a[k*5 +: 5] = pick_addr();
            for (int k = 0; k < 3; k++) ra_b[k*5 +: 5] = pick_addr();
            dra = pick_addr();
            step();
        end
        rst = 1'b0;
        idle();
        step();
        step();

        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0",
                     qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
